fir_sample_sched: RTL and testbench

//  Paces audio samples into the 32-tap FIR at a fixed sample rate (16 kHz).

---
 rtl/fir_sched_pkg.sv | 12 +
 rtl/sample_fifo.sv | 54 +++++
 rtl/fir_sample_sched.sv | 143 ++++++++++++++
 tb/tb_fir_sample_sched.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_sched_pkg.sv
// Shared types and widths for the FIR sample scheduler.
package fir_sched_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } sched_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO buffering upstream samples ahead of the sample tick.
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/fir_sample_sched.sv
// Paces buffered samples into the FIR once per sample tick, waits for the
// filter result under a watchdog and presents it on a valid/ready port.
//
// state | meaning
// IDLE  | waiting for a sample tick
// ISSUE | fir_x_valid high for one cycle, watchdog armed
// WAIT  | waiting for fir_y_valid or watchdog expiry
module fir_sample_sched
    import fir_sched_pkg::*;
#(
    parameter int TICK_DIV   = 3000,
    parameter int TIMEOUT    = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic signed [SAMPLE_W-1:0] s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic signed [SAMPLE_W-1:0] fir_x,
    output logic                       fir_x_valid,
    input  logic signed [SAMPLE_W-1:0] fir_y,
    input  logic                       fir_y_valid,
    output logic signed [SAMPLE_W-1:0] m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       tick,
    output logic                       err_underrun,
    output logic                       err_overrun,
    output logic                       err_timeout,
    input  logic                       clr_err
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TICK_LOAD = TW'(TICK_DIV - 1);
    localparam logic [WW-1:0] WD_LOAD   = WW'(TIMEOUT - 1);

    // A tick can only ever land in IDLE if the whole transaction fits between ticks.
    generate
        if (TICK_DIV < 4 || TIMEOUT < 1 || TIMEOUT >= TICK_DIV - 2 ||
            FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
            $error("fir_sample_sched: illegal TICK_DIV/TIMEOUT/FIFO_DEPTH combination");
        end
    endgenerate

    sched_state_t        state;
    logic [TW-1:0]       tick_cnt;
    logic [WW-1:0]       wd;
    logic [SAMPLE_W-1:0] fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;

    assign tick     = (tick_cnt == '0);
    assign s_ready  = !fifo_full;
    assign fifo_pop = (state == IDLE) && tick && !fifo_empty;

    sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (s_valid),
        .pop   (fifo_pop),
        .data  (s_data),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Down-counter to terminal count; dropping en re-arms a full sample period.
    always_ff @(posedge clk) begin
        if (reset || !en || tick_cnt == '0) begin
            tick_cnt <= TICK_LOAD;
        end else begin
            tick_cnt <= tick_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wd           <= '0;
            fir_x        <= '0;
            fir_x_valid  <= 1'b0;
            m_data       <= '0;
            m_valid      <= 1'b0;
            err_underrun <= 1'b0;
            err_overrun  <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            // Clear first so an error event later in this cycle wins.
            if (clr_err) begin
                err_underrun <= 1'b0;
                err_overrun  <= 1'b0;
                err_timeout  <= 1'b0;
            end
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            fir_x_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (tick) begin
                        state       <= ISSUE;
                        fir_x_valid <= 1'b1;
                        if (fifo_empty) begin
                            fir_x        <= '0;
                            err_underrun <= 1'b1;
                        end else begin
                            fir_x <= fifo_head;
                        end
                    end
                end
                ISSUE: begin
                    wd    <= WD_LOAD;
                    state <= WAIT;
                end
                WAIT: begin
                    if (fir_y_valid) begin
                        m_data  <= fir_y;
                        m_valid <= 1'b1;
                        if (m_valid && !m_ready) begin
                            err_overrun <= 1'b1;
                        end
                        state <= IDLE;
                    end else if (wd == '0) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wd <= wd - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_sample_sched.sv
// Bench for fir_sample_sched: directed scenarios plus random traffic, checked
// every cycle against a queue-based reference model and a stub FIR (y = x, 3 cycles).
module tb_fir_sample_sched;

    localparam int TICK_DIV   = 16;
    localparam int TIMEOUT    = 8;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] fir_x;
    logic        fir_x_valid;
    logic [15:0] fir_y = '0;
    logic        fir_y_valid = 1'b0;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        tick;
    logic        err_underrun;
    logic        err_overrun;
    logic        err_timeout;
    logic        clr_err;

    int n_cmp = 0;
    int n_bad = 0;
    int tcyc  = 0;
    bit chk_on = 1'b0;
    bit fir_en = 1'b1;

    fir_sample_sched #(
        .TICK_DIV   (TICK_DIV),
        .TIMEOUT    (TIMEOUT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .fir_x        (fir_x),
        .fir_x_valid  (fir_x_valid),
        .fir_y        (fir_y),
        .fir_y_valid  (fir_y_valid),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .tick         (tick),
        .err_underrun (err_underrun),
        .err_overrun  (err_overrun),
        .err_timeout  (err_timeout),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tcyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, tcyc);
        end
    endtask

    // Stub FIR: y = x, fir_y_valid three cycles after fir_x_valid.
    logic [2:0]  vp = '0;
    logic [15:0] dp [3];
    always @(posedge clk) begin
        vp    = {vp[1:0], (fir_x_valid === 1'b1) && fir_en};
        dp[2] = dp[1];
        dp[1] = dp[0];
        dp[0] = fir_x;
        #1;
        fir_y_valid = vp[2];
        fir_y       = dp[2];
    end

    // Reference model: sample queue, cycle numbers of the transaction, sticky flags.
    logic [15:0] q_fifo [$];
    int          r_en = 0;
    int          mcyc = 0;
    int          issue_cyc = 0;
    bit          busy = 1'b0;
    logic [15:0] e_fir_x = '0;
    logic [15:0] e_m_data = '0;
    bit          e_m_valid = 1'b0;
    bit          e_und = 1'b0;
    bit          e_ovr = 1'b0;
    bit          e_tmo = 1'b0;

    always @(posedge clk) begin : ref_model
        bit tick_now;
        bit full_pre;
        bit mv_pre;
        if (reset) begin
            q_fifo.delete();
            r_en = 0;
            busy = 1'b0;
            e_fir_x = '0;
            e_m_data = '0;
            e_m_valid = 1'b0;
            e_und = 1'b0;
            e_ovr = 1'b0;
            e_tmo = 1'b0;
        end else begin
            tick_now = (r_en % TICK_DIV) == TICK_DIV - 1;
            full_pre = q_fifo.size() >= FIFO_DEPTH;
            mv_pre   = e_m_valid;
            if (clr_err) begin
                e_und = 1'b0;
                e_ovr = 1'b0;
                e_tmo = 1'b0;
            end
            if (e_m_valid && m_ready) e_m_valid = 1'b0;
            if (!busy && tick_now) begin
                busy = 1'b1;
                issue_cyc = mcyc + 1;
                if (q_fifo.size() == 0) begin
                    e_fir_x = '0;
                    e_und = 1'b1;
                end else begin
                    e_fir_x = q_fifo.pop_front();
                end
            end else if (busy && mcyc > issue_cyc) begin
                if (fir_y_valid) begin
                    if (mv_pre && !m_ready) e_ovr = 1'b1;
                    e_m_data = fir_y;
                    e_m_valid = 1'b1;
                    busy = 1'b0;
                end else if (mcyc == issue_cyc + TIMEOUT) begin
                    e_tmo = 1'b1;
                    busy = 1'b0;
                end
            end
            if (s_valid && !full_pre) q_fifo.push_back(s_data);
            r_en = en ? r_en + 1 : 0;
        end
        mcyc++;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("tick", tick, ((r_en % TICK_DIV) == TICK_DIV - 1));
            chk("s_ready", s_ready, (q_fifo.size() < FIFO_DEPTH));
            chk("fir_x_valid", fir_x_valid, (busy && mcyc == issue_cyc));
            chk("fir_x", fir_x, e_fir_x);
            chk("m_valid", m_valid, e_m_valid);
            chk("m_data", m_data, e_m_data);
            chk("err_underrun", err_underrun, e_und);
            chk("err_overrun", err_overrun, e_ovr);
            chk("err_timeout", err_timeout, e_tmo);
        end
    end

    // Event log for the directed checks.
    logic [15:0] seen_x [$];
    int          seen_x_cyc [$];
    logic [15:0] seen_m [$];
    int          seen_t [$];
    always @(negedge clk) begin
        if (fir_x_valid === 1'b1) begin
            seen_x.push_back(fir_x);
            seen_x_cyc.push_back(tcyc);
        end
        if (m_valid === 1'b1 && m_ready) seen_m.push_back(m_data);
        if (tick === 1'b1) seen_t.push_back(tcyc);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [15:0] v);
        s_valid = 1'b1;
        s_data  = v;
        step();
        s_valid = 1'b0;
    endtask

    task automatic clr_pulse();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
    endtask

    task automatic clr_seen();
        seen_x.delete();
        seen_x_cyc.delete();
        seen_m.delete();
        seen_t.delete();
    endtask

    function automatic int cnt_of(input int kind);
        case (kind)
            0:       return seen_x.size();
            1:       return seen_m.size();
            default: return seen_t.size();
        endcase
    endfunction

    task automatic wait_count(input string name, input int kind, input int n, input int budget);
        int k = 0;
        while (cnt_of(kind) < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(name, (cnt_of(kind) >= n), 1);
    endtask

    function automatic logic [15:0] xat(input int i);
        return (i < seen_x.size()) ? seen_x[i] : 16'hdead;
    endfunction

    function automatic logic [15:0] mat(input int i);
        return (i < seen_m.size()) ? seen_m[i] : 16'hdead;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", tcyc);
        $fatal(1, "time limit");
    end

    initial begin
        int a;
        int k;
        reset = 1'b1;
        en = 1'b0;
        s_data = '0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        clr_err = 1'b0;
        step();
        chk_on = 1'b1;
        step();
        step();
        reset = 1'b0;
        @(negedge clk); #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 1);

        // 1: two queued samples, paced out one tick apart
        m_ready = 1'b1;
        clr_seen();
        push(16'h1000);
        push(16'h2000);
        en = 1'b1;
        wait_count("t1_results", 1, 2, 60);
        en = 1'b0;
        chk("t1_x0", xat(0), 16'h1000);
        chk("t1_x1", xat(1), 16'h2000);
        chk("t1_m0", mat(0), 16'h1000);
        chk("t1_m1", mat(1), 16'h2000);
        chk("t1_period", (seen_t.size() >= 2) ? seen_t[1] - seen_t[0] : 0, 16);
        chk("t1_issue_lat", (seen_x_cyc.size() >= 1 && seen_t.size() >= 1) ?
            seen_x_cyc[0] - seen_t[0] : 0, 1);
        repeat (4) step();

        // 2: five back-to-back pushes into a depth-4 FIFO
        clr_seen();
        for (int i = 0; i < 4; i++) push(16'h0A00 + 16'(i));
        s_valid = 1'b1;
        s_data  = 16'h0A04;
        @(negedge clk); #1;
        chk("t2_full", s_ready, 0);
        en = 1'b1;
        for (k = 0; k < 40 && !s_ready; k++) begin
            @(negedge clk); #1;
        end
        chk("t2_released", s_ready, 1);
        @(posedge clk); #2;
        s_valid = 1'b0;
        wait_count("t2_issues", 0, 5, 120);
        en = 1'b0;
        wait_count("t2_results", 1, 5, 20);
        for (int i = 0; i < 5; i++) chk("t2_order", xat(i), 16'h0A00 + 16'(i));

        // 3: empty FIFO zero-stuffs and flags underrun
        clr_seen();
        step();
        chk("t3_no_err", err_underrun, 0);
        en = 1'b1;
        wait_count("t3_issues", 0, 2, 40);
        en = 1'b0;
        chk("t3_x0", xat(0), 16'h0000);
        chk("t3_x1", xat(1), 16'h0000);
        chk("t3_underrun", err_underrun, 1);
        repeat (8) step();
        clr_pulse();
        @(negedge clk); #1;
        chk("t3_cleared", err_underrun, 0);

        // 4: downstream stalled across two results
        clr_seen();
        m_ready = 1'b0;
        push(16'h0100);
        push(16'h0200);
        en = 1'b1;
        wait_count("t4_issues", 0, 2, 40);
        en = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("t4_m_data", m_data, 16'h0200);
        chk("t4_overrun", err_overrun, 1);
        chk("t4_m_valid", m_valid, 1);
        m_ready = 1'b1;
        step();
        clr_pulse();

        // 5: FIR never answers
        clr_seen();
        fir_en = 1'b0;
        push(16'h0300);
        en = 1'b1;
        wait_count("t5_issue", 0, 1, 20);
        a = (seen_x_cyc.size() > 0) ? seen_x_cyc[0] : tcyc;
        while (tcyc < a + 8) begin
            @(negedge clk); #1;
        end
        chk("t5_tmo_early", err_timeout, 0);
        @(negedge clk); #1;
        chk("t5_tmo", err_timeout, 1);
        chk("t5_no_out", m_valid, 0);
        fir_en = 1'b1;
        push(16'h0400);
        wait_count("t5_next", 0, 2, 30);
        en = 1'b0;
        wait_count("t5_next_res", 1, 1, 10);
        chk("t5_next_x", xat(1), 16'h0400);
        chk("t5_next_m", mat(0), 16'h0400);
        chk("t5_sticky", err_timeout, 1);
        clr_pulse();

        // 6: reset in WAIT with two samples still queued
        clr_seen();
        push(16'h0500);
        push(16'h0600);
        push(16'h0700);
        en = 1'b1;
        wait_count("t6_issue", 0, 1, 20);
        en = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk); #1;
        chk("t6_s_ready", s_ready, 1);
        chk("t6_fir_x", fir_x, 0);
        chk("t6_m_data", m_data, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("t6_no_m_valid", m_valid, 0);
        end
        clr_seen();
        en = 1'b1;
        wait_count("t6_after", 0, 1, 20);
        en = 1'b0;
        chk("t6_fifo_empty", xat(0), 16'h0000);
        repeat (8) step();

        // random traffic
        en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            s_valid = 1'($urandom % 2);
            s_data  = 16'($urandom);
            m_ready = ($urandom % 4) != 0;
            clr_err = ($urandom % 64) == 0;
            fir_en  = ($urandom % 8) != 0;
            if ($urandom % 150 == 0) en = !en;
            reset   = (i == 700 || i == 701);
            step();
        end
        reset = 1'b0;
        en = 1'b0;
        s_valid = 1'b0;
        clr_err = 1'b0;
        m_ready = 1'b1;
        fir_en = 1'b1;
        repeat (30) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
